heart_model: RTL and testbench

HEART_MODEL -- requirements
Module: heart_model

---
 rtl/heart_model_if.sv | 23 ++
 rtl/heart_model.sv | 98 +++++++++
 tb/tb_heart_model.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/heart_model_if.sv
// Pacemaker <-> heart signal bundle: pace/block controls in, sense pulses and beat counts out.
interface heart_model_if;
    logic       pa;
    logic       pv;
    logic       a_block;
    logic       av_block;
    logic       sa;
    logic       sv;
    logic [7:0] a_beats;
    logic [7:0] v_beats;

    // Pacemaker / stimulus side
    modport master (
        output pa, pv, a_block, av_block,
        input  sa, sv, a_beats, v_beats
    );

    // Heart model side
    modport slave (
        input  pa, pv, a_block, av_block,
        output sa, sv, a_beats, v_beats
    );
endinterface

// File: rtl/heart_model.sv
// Behavioural heart: intrinsic atrial/ventricular rhythm with pace override,
// sinus arrest / AV block fault injection, and saturating beat counters.
module heart_model #(
    parameter int A_PERIOD  = 30,
    parameter int AV_DELAY  = 10,
    parameter int V_REFRACT = 4,
    parameter int TW        = 6
) (
    input  logic         clk,
    input  logic         rst,
    heart_model_if.slave bus
);

    typedef enum logic [2:0] {A_WAIT, A_SENSE, AV_WAIT, V_SENSE, REFRACT} state_t;

    localparam logic [TW-1:0] A_LOAD  = TW'(A_PERIOD - 1);
    localparam logic [TW-1:0] AV_LOAD = TW'(AV_DELAY - 1);
    localparam logic [TW-1:0] R_LOAD  = TW'(V_REFRACT - 1);
    localparam logic [7:0]    CNT_MAX = 8'hFF;

    state_t        state;
    logic [TW-1:0] timer;
    logic          sa_q;
    logic          sv_q;
    logic [7:0]    a_cnt;
    logic [7:0]    v_cnt;

    // Rhythm FSM; sense pulses are registered and asserted exactly while in the sense states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= A_WAIT;
            timer <= A_LOAD;
            sa_q  <= 1'b0;
            sv_q  <= 1'b0;
            a_cnt <= '0;
            v_cnt <= '0;
        end else begin
            sa_q <= 1'b0;
            sv_q <= 1'b0;
            // Free-running decrement; any state-entry load below overrides it
            if (timer != '0) timer <= timer - TW'(1);
            case (state)
                A_WAIT: begin
                    // Pace beats timer expiry, so no sense pulse on a coincident pace
                    if (bus.pa) begin
                        state <= AV_WAIT;
                        timer <= AV_LOAD;
                        if (a_cnt != CNT_MAX) a_cnt <= a_cnt + 8'd1;
                    end else if (timer == '0) begin
                        if (!bus.a_block) begin
                            state <= A_SENSE;
                            sa_q  <= 1'b1;
                        end else begin
                            timer <= A_LOAD;
                        end
                    end
                end
                A_SENSE: begin
                    state <= AV_WAIT;
                    timer <= AV_LOAD;
                    if (a_cnt != CNT_MAX) a_cnt <= a_cnt + 8'd1;
                end
                AV_WAIT: begin
                    // With AV block the timer parks at 0 and only a ventricular pace escapes
                    if (bus.pv) begin
                        state <= REFRACT;
                        timer <= R_LOAD;
                        if (v_cnt != CNT_MAX) v_cnt <= v_cnt + 8'd1;
                    end else if (timer == '0 && !bus.av_block) begin
                        state <= V_SENSE;
                        sv_q  <= 1'b1;
                    end
                end
                V_SENSE: begin
                    state <= REFRACT;
                    timer <= R_LOAD;
                    if (v_cnt != CNT_MAX) v_cnt <= v_cnt + 8'd1;
                end
                REFRACT: begin
                    if (timer == '0) begin
                        state <= A_WAIT;
                        timer <= A_LOAD;
                    end
                end
                default: begin
                    state <= A_WAIT;
                    timer <= A_LOAD;
                end
            endcase
        end
    end

    assign bus.sa      = sa_q;
    assign bus.sv      = sv_q;
    assign bus.a_beats = a_cnt;
    assign bus.v_beats = v_cnt;

endmodule

// File: tb/tb_heart_model.sv
// Scenario bench for heart_model: expected sense events are queued per scenario
// and matched by a negedge monitor; counters and reset behaviour are checked inline.
module tb_heart_model;

    typedef struct {
        logic is_v;
        int   cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    heart_model_if bus();

    heart_model dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int  cyc = 0;
    int  base = 0;
    int  asserts = 0;
    int  fails = 0;
    bit  track = 1'b0;
    ev_t exp_q[$];
    ev_t got;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every sense pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst && track) begin
            asserts++;
            if (bus.sa && bus.sv) begin
                fails++;
                $display("FAIL sa_sv_exclusive: both high at cycle %0d", cyc - base);
            end
            if (bus.sa || bus.sv) begin
                asserts++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard: unexpected %s at cycle %0d, none expected",
                             bus.sv ? "sv" : "sa", cyc - base);
                end else begin
                    got = exp_q.pop_front();
                    if (got.is_v !== bus.sv || got.cyc != cyc - base) begin
                        fails++;
                        $display("FAIL scoreboard: got %s at cycle %0d, expected %s at cycle %0d",
                                 bus.sv ? "sv" : "sa", cyc - base,
                                 got.is_v ? "sv" : "sa", got.cyc);
                    end
                end
            end
        end
    end

    task automatic push(input logic is_v, input int c);
        ev_t e;
        e.is_v = is_v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Returns 1 time unit after rising edge n (relative to reset release)
    task automatic wait_until(input int n);
        while ((cyc - base) < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        track        = 1'b0;
        rst          = 1'b0;
        bus.pa       = 1'b0;
        bus.pv       = 1'b0;
        bus.a_block  = 1'b0;
        bus.av_block = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        base  = cyc;
        track = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.pa = 1'b0; bus.pv = 1'b0; bus.a_block = 1'b0; bus.av_block = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        asserts += 4;
        if (bus.sa !== 1'b0) begin fails++; $display("FAIL reset_sa: got %b want 0", bus.sa); end
        if (bus.sv !== 1'b0) begin fails++; $display("FAIL reset_sv: got %b want 0", bus.sv); end
        if (bus.a_beats !== 8'd0) begin fails++; $display("FAIL reset_a_beats: got %0d want 0", bus.a_beats); end
        if (bus.v_beats !== 8'd0) begin fails++; $display("FAIL reset_v_beats: got %0d want 0", bus.v_beats); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push(1'b0, 30 + 46 * k);
            push(1'b1, 41 + 46 * k);
        end
        wait_until(30);
        asserts++;
        if (bus.a_beats !== 8'd0) begin fails++; $display("FAIL free_a_beats_30: got %0d want 0", bus.a_beats); end
        wait_until(31);
        asserts++;
        if (bus.a_beats !== 8'd1) begin fails++; $display("FAIL free_a_beats_31: got %0d want 1", bus.a_beats); end
        wait_until(470);
        asserts += 3;
        if (exp_q.size() != 0) begin fails++; $display("FAIL free_events: %0d expected events missing", exp_q.size()); end
        if (bus.a_beats !== 8'd10) begin fails++; $display("FAIL free_a_beats: got %0d want 10", bus.a_beats); end
        if (bus.v_beats !== 8'd10) begin fails++; $display("FAIL free_v_beats: got %0d want 10", bus.v_beats); end
    endtask

    task automatic test_ignored();
        do_reset();
        push(1'b0, 30); push(1'b1, 41); push(1'b0, 76);
        wait_until(35); bus.pa = 1'b1;   // sampled at edge 36, in AV_WAIT
        wait_until(36); bus.pa = 1'b0;
        wait_until(42); bus.pv = 1'b1;   // sampled at edge 43, in REFRACT
        wait_until(43); bus.pv = 1'b0;
        wait_until(80);
        asserts += 3;
        if (exp_q.size() != 0) begin fails++; $display("FAIL ignored_events: %0d expected events missing", exp_q.size()); end
        if (bus.a_beats !== 8'd2) begin fails++; $display("FAIL ignored_a_beats: got %0d want 2", bus.a_beats); end
        if (bus.v_beats !== 8'd1) begin fails++; $display("FAIL ignored_v_beats: got %0d want 1", bus.v_beats); end
    endtask

    task automatic test_a_block();
        do_reset();
        bus.a_block = 1'b1;
        push(1'b1, 36);
        wait_until(25); bus.pa = 1'b1;
        wait_until(26); bus.pa = 1'b0;
        wait_until(80);
        asserts += 3;
        if (exp_q.size() != 0) begin fails++; $display("FAIL ablock_events: %0d expected events missing", exp_q.size()); end
        if (bus.a_beats !== 8'd1) begin fails++; $display("FAIL ablock_a_beats: got %0d want 1", bus.a_beats); end
        if (bus.v_beats !== 8'd1) begin fails++; $display("FAIL ablock_v_beats: got %0d want 1", bus.v_beats); end
    endtask

    task automatic test_av_block();
        do_reset();
        bus.av_block = 1'b1;
        push(1'b0, 30); push(1'b0, 95);
        wait_until(60);
        asserts++;
        if (bus.v_beats !== 8'd0) begin fails++; $display("FAIL avblock_v_before_pv: got %0d want 0", bus.v_beats); end
        bus.pv = 1'b1;
        wait_until(61); bus.pv = 1'b0;
        wait_until(100);
        asserts += 3;
        if (exp_q.size() != 0) begin fails++; $display("FAIL avblock_events: %0d expected events missing", exp_q.size()); end
        if (bus.a_beats !== 8'd2) begin fails++; $display("FAIL avblock_a_beats: got %0d want 2", bus.a_beats); end
        if (bus.v_beats !== 8'd1) begin fails++; $display("FAIL avblock_v_beats: got %0d want 1", bus.v_beats); end
    endtask

    task automatic test_coincide();
        do_reset();
        push(1'b1, 40);
        wait_until(29); bus.pa = 1'b1;   // sampled at edge 30, same edge the timer expires
        wait_until(30); bus.pa = 1'b0;
        wait_until(31);
        asserts++;
        if (bus.a_beats !== 8'd1) begin fails++; $display("FAIL coincide_a_beats_31: got %0d want 1", bus.a_beats); end
        wait_until(60);
        asserts += 3;
        if (exp_q.size() != 0) begin fails++; $display("FAIL coincide_events: %0d expected events missing", exp_q.size()); end
        if (bus.a_beats !== 8'd1) begin fails++; $display("FAIL coincide_a_beats: got %0d want 1", bus.a_beats); end
        if (bus.v_beats !== 8'd1) begin fails++; $display("FAIL coincide_v_beats: got %0d want 1", bus.v_beats); end
    endtask

    task automatic test_saturate();
        do_reset();
        track = 1'b0;
        wait_until(300 * 46 + 40);
        asserts += 2;
        if (bus.a_beats !== 8'd255) begin fails++; $display("FAIL sat_a_beats: got %0d want 255", bus.a_beats); end
        if (bus.v_beats !== 8'd255) begin fails++; $display("FAIL sat_v_beats: got %0d want 255", bus.v_beats); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        track = 1'b0;
        wait_until(76);
        asserts += 2;
        if (bus.sa !== 1'b1) begin fails++; $display("FAIL mid_sa_before: got %b want 1", bus.sa); end
        if (bus.a_beats !== 8'd1) begin fails++; $display("FAIL mid_a_beats_before: got %0d want 1", bus.a_beats); end
        #2;
        rst = 1'b0;
        #1;
        asserts += 4;
        if (bus.sa !== 1'b0) begin fails++; $display("FAIL mid_sa_after: got %b want 0", bus.sa); end
        if (bus.sv !== 1'b0) begin fails++; $display("FAIL mid_sv_after: got %b want 0", bus.sv); end
        if (bus.a_beats !== 8'd0) begin fails++; $display("FAIL mid_a_beats_after: got %0d want 0", bus.a_beats); end
        if (bus.v_beats !== 8'd0) begin fails++; $display("FAIL mid_v_beats_after: got %0d want 0", bus.v_beats); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ignored();
        test_a_block();
        test_av_block();
        test_coincide();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
